// File: rtl/bank_register_sb.sv
// rtl/bank_register_sb.sv - register bank with write bypass and pending scoreboard
module bank_register_sb #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int BYPASS = 1,
   parameter int PRESET = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] rd_addr0,
   input  logic [ADDR_W-1:0] rd_addr1,
   output logic [DATA_W-1:0] rd_data0,
   output logic [DATA_W-1:0] rd_data1,
   output logic              rd_busy0,
   output logic              rd_busy1,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rsv_en,
   input  logic [ADDR_W-1:0] rsv_addr,
   output logic [ADDR_W:0]   pend_cnt,
   output logic              wr_unexp
);

   localparam int NREGS = 1 << ADDR_W;
   localparam logic [ADDR_W:0] CNT_ONE = 1;

   logic [DATA_W-1:0] regs [NREGS];
   logic [NREGS-1:0]  pending;
   logic [NREGS-1:0]  pend_next;

   logic [ADDR_W-1:0] ra    [2];
   logic [DATA_W-1:0] rdv   [2];
   logic              busyv [2];

   logic wr_hit, rsv_hit, cnt_inc, cnt_dec;

   function automatic logic [DATA_W-1:0] preset_val(input int idx);
      preset_val = '0;
      if (PRESET != 0 && NREGS >= 8) begin
         case (idx)
            1:          preset_val = DATA_W'(4);
            2:          preset_val = DATA_W'(1);
            3:          preset_val = DATA_W'(9);
            4, 5, 6, 7: preset_val = DATA_W'(1);
            default:    preset_val = '0;
         endcase
      end
   endfunction

   assign ra[0] = rd_addr0;
   assign ra[1] = rd_addr1;

   // A same-cycle write both forwards its data and retires the busy flag,
   // unless a new producer reserves the same register in that cycle.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rdv[p]   = regs[ra[p]];
         busyv[p] = pending[ra[p]];
         if (ra[p] == '0) begin
            rdv[p]   = '0;
            busyv[p] = 1'b0;
         end else if (BYPASS != 0 && wr_en && wr_addr == ra[p]) begin
            rdv[p] = wr_data;
            if (!(rsv_en && rsv_addr == ra[p]))
               busyv[p] = 1'b0;
         end
      end
   end

   assign rd_data0 = rdv[0];
   assign rd_data1 = rdv[1];
   assign rd_busy0 = busyv[0];
   assign rd_busy1 = busyv[1];

   assign wr_hit  = wr_en && (wr_addr != '0);
   assign rsv_hit = rsv_en && (rsv_addr != '0);

   // Write clears first, reserve sets last, so a same-address pair stays pending.
   always_comb begin
      pend_next = pending;
      if (wr_hit)
         pend_next[wr_addr] = 1'b0;
      if (rsv_hit)
         pend_next[rsv_addr] = 1'b1;
   end

   assign cnt_inc = rsv_hit && !pending[rsv_addr];
   assign cnt_dec = wr_hit && pending[wr_addr] && !(rsv_hit && rsv_addr == wr_addr);

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++)
            regs[i] <= preset_val(i);
         pending  <= '0;
         pend_cnt <= '0;
         wr_unexp <= 1'b0;
      end else begin
         if (wr_hit)
            regs[wr_addr] <= wr_data;
         pending  <= pend_next;
         wr_unexp <= wr_hit && !pending[wr_addr];
         case ({cnt_inc, cnt_dec})
            2'b10:   pend_cnt <= pend_cnt + CNT_ONE;
            2'b01:   pend_cnt <= pend_cnt - CNT_ONE;
            default: pend_cnt <= pend_cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_bank_register_sb.sv
// tb/tb_bank_register_sb.sv - randomized bench for bank_register_sb against a reference model
module tb_bank_register_sb;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  rd_addr0, rd_addr1, wr_addr, rsv_addr;
   logic [31:0] wr_data;
   logic        wr_en, rsv_en;

   logic [31:0] b_rd0, b_rd1, n_rd0, n_rd1;
   logic        b_busy0, b_busy1, n_busy0, n_busy1;
   logic [5:0]  b_cnt, n_cnt;
   logic        b_unexp, n_unexp;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] m_regs [32];
   bit          m_pend [32];
   bit          m_unexp;

   always #5 clk = ~clk;

   bank_register_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1), .PRESET(1)) dut (
      .clk(clk), .reset(reset),
      .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
      .rd_data0(b_rd0), .rd_data1(b_rd1),
      .rd_busy0(b_busy0), .rd_busy1(b_busy1),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr),
      .pend_cnt(b_cnt), .wr_unexp(b_unexp)
   );

   bank_register_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(0), .PRESET(1)) dut_nb (
      .clk(clk), .reset(reset),
      .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
      .rd_data0(n_rd0), .rd_data1(n_rd1),
      .rd_busy0(n_busy0), .rd_busy1(n_busy1),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr),
      .pend_cnt(n_cnt), .wr_unexp(n_unexp)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] preset(input int i);
      case (i)
         1:       return 32'd4;
         2:       return 32'd1;
         3:       return 32'd9;
         4, 5, 6, 7: return 32'd1;
         default: return 32'd0;
      endcase
   endfunction

   function automatic int model_cnt();
      int c = 0;
      for (int i = 0; i < 32; i++)
         c += int'(m_pend[i]);
      return c;
   endfunction

   function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
      if (a == 0) return 32'd0;
      if (byp && wr_en && wr_addr == a) return wr_data;
      return m_regs[a];
   endfunction

   function automatic bit exp_busy(input logic [4:0] a, input bit byp);
      if (a == 0) return 1'b0;
      if (byp && wr_en && wr_addr == a && !(rsv_en && rsv_addr == a)) return 1'b0;
      return m_pend[a];
   endfunction

   task automatic model_step();
      if (!reset) begin
         for (int i = 0; i < 32; i++) begin
            m_regs[i] = preset(i);
            m_pend[i] = 1'b0;
         end
         m_unexp = 1'b0;
      end else begin
         m_unexp = wr_en && wr_addr != 0 && !m_pend[wr_addr];
         if (wr_en && wr_addr != 0) begin
            m_regs[wr_addr] = wr_data;
            m_pend[wr_addr] = 1'b0;
         end
         if (rsv_en && rsv_addr != 0)
            m_pend[rsv_addr] = 1'b1;
      end
   endtask

   task automatic check_all();
      if (reset) begin
         chk("b_rd0",   b_rd0,   exp_rd(rd_addr0, 1'b1));
         chk("b_rd1",   b_rd1,   exp_rd(rd_addr1, 1'b1));
         chk("n_rd0",   n_rd0,   exp_rd(rd_addr0, 1'b0));
         chk("n_rd1",   n_rd1,   exp_rd(rd_addr1, 1'b0));
         chk("b_busy0", b_busy0, exp_busy(rd_addr0, 1'b1));
         chk("b_busy1", b_busy1, exp_busy(rd_addr1, 1'b1));
         chk("n_busy0", n_busy0, exp_busy(rd_addr0, 1'b0));
         chk("n_busy1", n_busy1, exp_busy(rd_addr1, 1'b0));
      end
      chk("b_cnt",   b_cnt,   model_cnt());
      chk("n_cnt",   n_cnt,   model_cnt());
      chk("b_unexp", b_unexp, m_unexp);
      chk("n_unexp", n_unexp, m_unexp);
   endtask

   task automatic set_in(input logic rst, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic rse, input logic [4:0] rsa,
                         input logic [4:0] a0, input logic [4:0] a1);
      reset = rst; wr_en = we; wr_addr = wa; wr_data = wd;
      rsv_en = rse; rsv_addr = rsa; rd_addr0 = a0; rd_addr1 = a1;
      @(negedge clk);
      check_all();
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   function automatic logic [4:0] raddr();
      if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
      return 5'($urandom_range(0, 7));
   endfunction

   initial begin
      reset = 1'b0; wr_en = 1'b0; rsv_en = 1'b0;
      wr_addr = '0; rsv_addr = '0; wr_data = '0; rd_addr0 = '0; rd_addr1 = '0;
      tick();

      set_in(1, 0, 0, 0, 0, 0, 1, 3);
      chk("preset_r1", b_rd0, 32'd4);
      chk("preset_r3", b_rd1, 32'd9);
      chk("reset_cnt", b_cnt, 6'd0);
      chk("reset_busy", b_busy0, 1'b0);
      tick();
      set_in(1, 0, 0, 0, 0, 0, 7, 8);
      chk("preset_r7", b_rd0, 32'd1);
      chk("preset_r8", b_rd1, 32'd0);
      tick();

      set_in(1, 1, 5, 32'hDEADBEEF, 0, 0, 5, 5);
      chk("byp_same", b_rd0, 32'hDEADBEEF);
      chk("nobyp_same", n_rd0, 32'd1);
      tick();
      set_in(1, 0, 0, 0, 0, 0, 5, 5);
      chk("nobyp_next", n_rd0, 32'hDEADBEEF);
      chk("unexp_w5", b_unexp, 1'b1);
      tick();

      set_in(1, 0, 0, 0, 1, 9, 9, 10);
      tick();
      set_in(1, 0, 0, 0, 1, 10, 9, 10);
      chk("busy9", b_busy0, 1'b1);
      chk("cnt_1", b_cnt, 6'd1);
      tick();
      set_in(1, 1, 9, 32'h99, 0, 0, 10, 9);
      chk("cnt_2", b_cnt, 6'd2);
      chk("busy10", b_busy0, 1'b1);
      chk("byp_busy9_clr", b_busy1, 1'b0);
      chk("nobyp_busy9", n_busy1, 1'b1);
      tick();
      set_in(1, 0, 0, 0, 0, 0, 10, 9);
      chk("cnt_back1", b_cnt, 6'd1);
      chk("unexp_w9", b_unexp, 1'b0);
      chk("busy10_hold", b_busy0, 1'b1);
      tick();

      set_in(1, 0, 0, 0, 1, 12, 12, 0);
      tick();
      set_in(1, 1, 12, 32'h1234, 1, 12, 12, 0);
      tick();
      set_in(1, 1, 13, 32'd77, 0, 0, 12, 13);
      chk("rd12", b_rd0, 32'h1234);
      chk("busy12", b_busy0, 1'b1);
      chk("cnt_wr_rsv", b_cnt, 6'd2);
      tick();
      set_in(1, 0, 0, 0, 0, 0, 12, 13);
      chk("unexp13_on", b_unexp, 1'b1);
      tick();
      set_in(1, 0, 0, 0, 0, 0, 12, 13);
      chk("unexp13_off", b_unexp, 1'b0);
      tick();

      set_in(1, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0);
      chk("r0_rd", b_rd0, 32'd0);
      chk("r0_busy", b_busy0, 1'b0);
      tick();
      set_in(1, 0, 0, 0, 0, 0, 0, 0);
      chk("r0_cnt", b_cnt, 6'd2);
      chk("r0_unexp", b_unexp, 1'b0);
      tick();

      set_in(1, 0, 0, 0, 1, 20, 20, 21);
      tick();
      set_in(1, 0, 0, 0, 1, 21, 20, 21);
      tick();
      set_in(0, 1, 3, 32'hAAAA, 1, 22, 20, 3);
      tick();
      set_in(1, 0, 0, 0, 0, 0, 20, 3);
      chk("rst_cnt", b_cnt, 6'd0);
      chk("rst_busy", b_busy0, 1'b0);
      chk("rst_r3", b_rd1, 32'd9);
      tick();

      for (int i = 1; i < 32; i++) begin
         set_in(1, 0, 0, 0, 1, 5'(i), 5'(i), 0);
         tick();
      end
      set_in(1, 0, 0, 0, 1, 5, 31, 1);
      chk("cnt_max", b_cnt, 6'd31);
      tick();
      set_in(1, 0, 0, 0, 0, 0, 31, 1);
      chk("cnt_max_hold", b_cnt, 6'd31);
      tick();

      for (int i = 0; i < 3000; i++) begin
         set_in(logic'($urandom_range(0, 199) != 0), logic'($urandom_range(0, 1)), raddr(),
                $urandom(), logic'($urandom_range(0, 1)), raddr(), raddr(), raddr());
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
